snn_sram_rmw_ctrl: RTL and testbench
====================================

Name: snn_sram_rmw_ctrl

Overview:
- Initiator-side controller for the 8192x32 single-port neuron-state SRAM.
- Accepts read, write and read-modify-write (RMW) commands from the neuron update engine over a valid/ready interface, and drives the SRAM CS/WE/A/D pins.
- Consumes Q, which the SRAM registers one cycle after the edge that samples CS.
- RMW does a saturating signed add on the membrane-potential field (bits [FW-1:0]) and preserves the upper bits.

Parameters:
- AW, 13, SRAM address width.
- DW, 32, SRAM data width.
- FW, 16, width of the signed membrane-potential field at bits [FW-1:0].

Ports:
- CK  in  1  clock; all logic is posedge.
- RST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept.
- cmd_op  in  2  00=READ, 01=WRITE, 10=RMW_ADD, 11=reserved.
- cmd_addr  in  AW  word address.
- cmd_data  in  DW  WRITE: full word. RMW_ADD: signed delta in [FW-1:0], upper bits ignored.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DW  READ: word read. RMW_ADD: updated word as written back.
- sram_cs  out  1  SRAM CS, registered.
- sram_we  out  1  SRAM WE, registered.
- sram_a  out  AW  SRAM A, registered.
- sram_d  out  DW  SRAM D, registered.
- sram_q  in  DW  SRAM Q.
- sat_count  out  16  count of RMW ops that saturated; sticks at 0xFFFF.

Behaviour:
- Reset (async, RST_N low): state=IDLE; sram_cs=0, sram_we=0, sram_a=0, sram_d=0, rsp_valid=0, rsp_data=0, sat_count=0.
  - Because the SRAM pins are registered with async reset, asserting reset mid-operation drops CS immediately. A write being driven in that cycle is not performed.
  - An accepted command interrupted by reset is lost and produces no response.
- cmd_ready = (state==IDLE). One command in flight at a time, so there are no address hazards.
- States: IDLE, RD, CAP, WR, RSP.
- IDLE: on cmd_valid&cmd_ready at edge E0:
  - READ or RMW_ADD: register cs=1, we=0, a=cmd_addr; latch op and delta; go to RD.
  - WRITE: register cs=1, we=1, a=cmd_addr, d=cmd_data; go to WR.
  - reserved op: accept, issue nothing, produce no response, stay IDLE.
- RD: SRAM samples at E1. Register cs=0, we=0; go to CAP. Q is valid after E1 and stays stable while CS=0.
- CAP (edge E2):
  - READ: rsp_data<=sram_q; rsp_valid<=1; go to RSP. Latency: accept E0 to rsp_valid high after E2 = 2 cycles.
  - RMW_ADD: compute new = {sram_q[DW-1:FW], sat(sram_q[FW-1:0] + delta)}. Register cs=1, we=1, a unchanged, d=new, rsp_data<=new; go to WR. If saturation occurred, increment sat_count (sticks at 0xFFFF).
- WR (edge following entry): SRAM writes. Register cs=0, we=0.
  - From WRITE: return to IDLE. cmd_ready is low for exactly 1 cycle; no response.
  - From RMW_ADD: rsp_valid<=1; go to RSP. Latency accept to rsp_valid = 3 cycles.
- RSP: hold rsp_valid and rsp_data stable until rsp_valid&rsp_ready, then rsp_valid<=0 and go to IDLE. The next command can be accepted on the edge after the handshake.
- Saturation arithmetic:
  - Form a signed FW+1 bit sum.
  - If the sum > 2^(FW-1)-1, clamp to 0x7FFF. If the sum < -2^(FW-1), clamp to 0x8000.
  - Otherwise truncate to FW bits.
- sram_a holds its last value when idle. sram_d changes only on write issue.
- sram_cs=1 for exactly one cycle per SRAM access.

Decomposition:
- Package snn_mem_pkg:
  - op encodings OP_READ/OP_WRITE/OP_RMW_ADD;
  - state enum;
  - AW/DW/FW defaults;
  - FW-bit min/max constants.
- Sub-module snn_sat_add: combinational FW-bit signed saturating adder with outputs sum and sat flag. It is used once in CAP.

Test Plan:
- After reset, WRITE addr 0x0005 data 0xDEADBEEF -> sram_cs=sram_we=1 for one cycle with a=0x0005; cmd_ready low 1 cycle; no rsp_valid.
- READ addr 0x0005 with rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_data=0xDEADBEEF; exactly one cs pulse with we=0.
- Preload 0x12347FF0, RMW_ADD delta 0x0020 -> rsp_data=0x12347FFF; memory word=0x12347FFF; sat_count=1. Then delta 0xFFF0 (-16) -> 0x12347FEF; sat_count stays 1.
- Preload 0x00008005, RMW_ADD delta 0x8000 -> 0x00008000, sat_count increments. Delta 0x0003 on 0x0000FFFE -> 0x00000001, no saturation.
- Hold rsp_ready=0 for 5 cycles after a READ response -> rsp_valid and rsp_data stable, cmd_ready=0, no SRAM activity. Release -> handshake, then IDLE.
- Assert RST_N low during the RMW WR cycle -> sram_cs drops immediately; memory keeps the old value; rsp_valid=0; after reset release cmd_ready=1.

Source files
------------

// File: rtl/snn_mem_pkg.sv
// Shared definitions for the neuron-state SRAM read-modify-write controller.
// Contents:
//   AW_DEF/DW_DEF/FW_DEF  default address, data and membrane-field widths
//   FW_MAX/FW_MIN         clamp limits of the signed membrane field (default FW)
//   op_t                  command opcodes carried on cmd_op
//   state_t               controller FSM states
package snn_mem_pkg;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 32;
  localparam int FW_DEF = 16;

  localparam logic [FW_DEF-1:0] FW_MAX = {1'b0, {(FW_DEF-1){1'b1}}};
  localparam logic [FW_DEF-1:0] FW_MIN = {1'b1, {(FW_DEF-1){1'b0}}};

  localparam logic [15:0] SAT_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RMW_ADD = 2'b10,
    OP_RSVD    = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RSP
  } state_t;

endpackage

// File: rtl/snn_sram_rmw_ctrl_if.sv
// Command/response channel between the neuron update engine and the SRAM
// read-modify-write controller. Both directions use valid/ready handshakes.
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data  engine -> controller
//   rsp_valid/rsp_ready/rsp_data                  controller -> engine
// Modports: master = update engine, slave = controller.
interface snn_sram_rmw_ctrl_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/snn_sat_add.sv
// Combinational FW-bit signed saturating adder for the membrane potential.
// Ports:
//   a, b  in   FW-bit two's complement operands
//   sum   out  a+b clamped to [-2^(FW-1), 2^(FW-1)-1]
//   sat   out  high when clamping took place
module snn_sat_add #(
  parameter int FW = 16
) (
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic [FW-1:0] sum,
  output logic          sat
);
  localparam logic [FW-1:0] MAX_V = {1'b0, {(FW-1){1'b1}}};
  localparam logic [FW-1:0] MIN_V = {1'b1, {(FW-1){1'b0}}};

  logic [FW:0] wide;

  // One guard bit is enough: overflow shows up as the top two bits differing,
  // and the guard bit then carries the true sign of the exact sum.
  assign wide = {a[FW-1], a} + {b[FW-1], b};
  assign sat  = wide[FW] ^ wide[FW-1];
  assign sum  = sat ? (wide[FW] ? MIN_V : MAX_V) : wide[FW-1:0];
endmodule

// File: rtl/snn_sram_rmw_ctrl.sv
// Initiator-side controller for the single-port neuron-state SRAM.
// Executes READ, WRITE and RMW_ADD commands one at a time and drives
// registered CS/WE/A/D pins; Q is returned by the SRAM one cycle after the
// edge that samples CS.
// Ports:
//   CK, RST_N      clock (posedge) and asynchronous active-low reset
//   bus            command/response channel (slave side)
//   sram_cs/we/a/d registered SRAM pins
//   sram_q         SRAM read data
//   sat_count      saturating count of RMW operations that clamped
module snn_sram_rmw_ctrl
  import snn_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic                 CK,
  input  logic                 RST_N,
  snn_sram_rmw_ctrl_if.slave   bus,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [AW-1:0]        sram_a,
  output logic [DW-1:0]        sram_d,
  input  logic [DW-1:0]        sram_q,
  output logic [15:0]          sat_count
);

  state_t        state_reg, state_next;
  op_t           op_reg, op_next;
  logic [FW-1:0] delta_reg, delta_next;
  logic          cs_reg, cs_next;
  logic          we_reg, we_next;
  logic [AW-1:0] a_reg, a_next;
  logic [DW-1:0] d_reg, d_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0] rsp_data_reg, rsp_data_next;
  logic [15:0]   sat_count_reg, sat_count_next;

  logic [FW-1:0] field_sum;
  logic          field_sat;
  logic [DW-1:0] new_word;

  snn_sat_add #(.FW(FW)) u_sat_add (
    .a   (sram_q[FW-1:0]),
    .b   (delta_reg),
    .sum (field_sum),
    .sat (field_sat)
  );

  // Only the membrane field is updated; the remaining state bits pass through.
  assign new_word = {sram_q[DW-1:FW], field_sum};

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_READ;
      delta_reg     <= '0;
      cs_reg        <= 1'b0;
      we_reg        <= 1'b0;
      a_reg         <= '0;
      d_reg         <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      sat_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      delta_reg     <= delta_next;
      cs_reg        <= cs_next;
      we_reg        <= we_next;
      a_reg         <= a_next;
      d_reg         <= d_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      sat_count_reg <= sat_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    delta_next     = delta_reg;
    cs_next        = cs_reg;
    we_next        = we_reg;
    a_next         = a_reg;
    d_next         = d_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    sat_count_next = sat_count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (op_t'(bus.cmd_op))
            OP_READ, OP_RMW_ADD: begin
              cs_next    = 1'b1;
              we_next    = 1'b0;
              a_next     = bus.cmd_addr;
              op_next    = op_t'(bus.cmd_op);
              delta_next = bus.cmd_data[FW-1:0];
              state_next = ST_RD;
            end
            OP_WRITE: begin
              cs_next    = 1'b1;
              we_next    = 1'b1;
              a_next     = bus.cmd_addr;
              d_next     = bus.cmd_data;
              op_next    = OP_WRITE;
              state_next = ST_WR;
            end
            default: ; // reserved opcode is consumed and dropped
          endcase
        end
      end

      ST_RD: begin
        // SRAM samples the read on this edge; Q becomes valid afterwards.
        cs_next    = 1'b0;
        we_next    = 1'b0;
        state_next = ST_CAP;
      end

      ST_CAP: begin
        if (op_reg == OP_READ) begin
          rsp_data_next  = sram_q;
          rsp_valid_next = 1'b1;
          state_next     = ST_RSP;
        end else begin
          cs_next       = 1'b1;
          we_next       = 1'b1;
          d_next        = new_word;
          rsp_data_next = new_word;
          state_next    = ST_WR;
          if (field_sat && (sat_count_reg != SAT_COUNT_MAX)) begin
            sat_count_next = sat_count_reg + 16'd1;
          end
        end
      end

      ST_WR: begin
        cs_next = 1'b0;
        we_next = 1'b0;
        if (op_reg == OP_RMW_ADD) begin
          rsp_valid_next = 1'b1;
          state_next     = ST_RSP;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign sram_cs       = cs_reg;
  assign sram_we       = we_reg;
  assign sram_a        = a_reg;
  assign sram_d        = d_reg;
  assign sat_count     = sat_count_reg;

endmodule

// File: tb/tb_snn_sram_rmw_ctrl.sv
// Self-checking bench for snn_sram_rmw_ctrl: behavioural SRAM, integer
// reference model of memory contents and saturation count, directed and
// random command sequences.
module tb_snn_sram_rmw_ctrl;

  logic        CK;
  logic        RST_N;
  logic        sram_cs, sram_we;
  logic [12:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;
  logic [15:0] sat_count;

  snn_sram_rmw_ctrl_if #(.AW(13), .DW(32)) bus ();

  snn_sram_rmw_ctrl #(.AW(13), .DW(32), .FW(16)) dut (
    .CK        (CK),
    .RST_N     (RST_N),
    .bus       (bus),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q),
    .sat_count (sat_count)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioural single-port SRAM with registered Q.
  logic [31:0] mem [0:8191];
  always @(posedge CK) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_a] <= sram_d;
      else         sram_q      <= mem[sram_a];
    end
  end

  // Access monitors: cycles with CS high and with a write strobe.
  int cs_cnt = 0;
  int wr_cnt = 0;
  always @(negedge CK) begin
    if (sram_cs) cs_cnt = cs_cnt + 1;
    if (sram_cs && sram_we) wr_cnt = wr_cnt + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [31:0] ref_mem [int];
  int          ref_sat = 0;

  function automatic logic [31:0] ref_rmw(input logic [31:0] old_w, input logic [31:0] dlt,
                                          output bit sat);
    int lo, dl, s;
    lo  = $signed(old_w[15:0]);
    dl  = $signed(dlt[15:0]);
    s   = lo + dl;
    sat = 1'b0;
    if (s > 32767) begin
      s = 32767; sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768; sat = 1'b1;
    end
    return {old_w[31:16], s[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one command with rsp_ready high, check handshake timing, response,
  // SRAM activity and the resulting memory word against the model.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [12:0] addr,
                         input logic [31:0] data);
    logic [31:0] exp_word;
    bit          sat;
    int          lat, n, cs0, wr0, exp_cs, exp_wr;
    exp_word = 32'h0;
    lat = 0; exp_cs = 0; exp_wr = 0;
    case (op)
      2'b00: begin
        exp_word = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        lat = 2; exp_cs = 1;
      end
      2'b01: begin
        ref_mem[addr] = data; exp_cs = 1; exp_wr = 1;
      end
      2'b10: begin
        exp_word = ref_rmw(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, data, sat);
        ref_mem[addr] = exp_word;
        if (sat && ref_sat < 65535) ref_sat++;
        lat = 3; exp_cs = 2; exp_wr = 1;
      end
      default: ;
    endcase
    cs0 = cs_cnt; wr0 = wr_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
    bus.rsp_ready = 1'b1;
    @(posedge CK); #1;
    bus.cmd_valid = 1'b0;
    if (op == 2'b11) begin
      chk({tag, " rsvd_ready"}, 32'(bus.cmd_ready), 32'd1);
      repeat (3) @(posedge CK);
      #1;
      chk({tag, " rsvd_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
    end else if (op == 2'b01) begin
      chk({tag, " wr_ready_low"}, 32'(bus.cmd_ready), 32'd0);
      @(posedge CK); #1;
      chk({tag, " wr_ready_back"}, 32'(bus.cmd_ready), 32'd1);
      chk({tag, " wr_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
    end else begin
      n = 0;
      while (n <= 10) begin
        @(posedge CK); #1;
        n++;
        if (bus.rsp_valid) break;
      end
      chk({tag, " latency"}, 32'(n), 32'(lat));
      chk({tag, " rsp_data"}, bus.rsp_data, exp_word);
      @(posedge CK); #1;
      chk({tag, " rsp_done"}, {31'h0, bus.rsp_valid}, 32'd0);
      chk({tag, " idle_after"}, 32'(bus.cmd_ready), 32'd1);
    end
    chk({tag, " cs_cycles"}, 32'(cs_cnt - cs0), 32'(exp_cs));
    chk({tag, " wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (op != 2'b11 && ref_mem.exists(addr)) chk({tag, " mem"}, mem[addr], ref_mem[addr]);
    chk({tag, " sat_count"}, 32'(sat_count), 32'(ref_sat));
    $display("txn %s op=%0d addr=%h data=%h rsp=%h sat=%0d", tag, op, addr, data,
             bus.rsp_data, sat_count);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst cs", 32'(sram_cs), 32'd0);
    chk("rst we", 32'(sram_we), 32'd0);
    chk("rst a", 32'(sram_a), 32'd0);
    chk("rst d", sram_d, 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_data", bus.rsp_data, 32'd0);
    chk("rst sat_count", 32'(sat_count), 32'd0);
    RST_N = 1'b1;
    @(posedge CK); #1;
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic test_write_read();
    run_cmd("write5", 2'b01, 13'h0005, 32'hDEADBEEF);
    chk("write5 a", 32'(sram_a), 32'h5);
    run_cmd("read5", 2'b00, 13'h0005, 32'h0);
  endtask

  task automatic test_rmw_sat();
    run_cmd("pre_a", 2'b01, 13'h0010, 32'h12347FF0);
    run_cmd("rmw_pos_sat", 2'b10, 13'h0010, 32'h00000020);
    chk("rmw_pos_sat word", ref_mem[13'h0010], 32'h12347FFF);
    run_cmd("rmw_neg16", 2'b10, 13'h0010, 32'h0000FFF0);
    chk("rmw_neg16 word", mem[13'h0010], 32'h12347FEF);
    run_cmd("pre_b", 2'b01, 13'h0011, 32'h00008005);
    run_cmd("rmw_neg_sat", 2'b10, 13'h0011, 32'hABCD8000);
    chk("rmw_neg_sat word", mem[13'h0011], 32'h00008000);
    run_cmd("pre_c", 2'b01, 13'h0012, 32'h0000FFFE);
    run_cmd("rmw_wrap", 2'b10, 13'h0012, 32'h00000003);
    chk("rmw_wrap word", mem[13'h0012], 32'h00000001);
    chk("sat_total", 32'(sat_count), 32'd2);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int n, cs0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_addr = 13'h0005; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    @(posedge CK); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (n <= 10 && !bus.rsp_valid) begin
      @(posedge CK); #1;
      n++;
    end
    chk("bp latency", 32'(n), 32'd2);
    held = bus.rsp_data;
    cs0 = cs_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge CK); #1;
      chk("bp valid_held", 32'(bus.rsp_valid), 32'd1);
      chk("bp data_held", bus.rsp_data, 32'hDEADBEEF);
      chk("bp ready_low", 32'(bus.cmd_ready), 32'd0);
    end
    chk("bp no_sram", 32'(cs_cnt - cs0), 32'd0);
    chk("bp data_stable", bus.rsp_data, held);
    bus.rsp_ready = 1'b1;
    @(posedge CK); #1;
    chk("bp released", 32'(bus.rsp_valid), 32'd0);
    chk("bp idle", 32'(bus.cmd_ready), 32'd1);
    $display("txn backpressure read addr=0005 rsp=%h", held);
  endtask

  task automatic test_reserved();
    run_cmd("reserved", 2'b11, 13'h0005, 32'h11111111);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [12:0] addr;
    for (int i = 0; i < 8; i++) run_cmd("rnd_init", 2'b01, 13'h0100 + 13'(i), $urandom);
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 2));
      addr = 13'h0100 + 13'($urandom_range(0, 7));
      // Bias deltas toward large magnitudes so saturation is exercised often.
      run_cmd("rnd", op, addr, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_reset_mid_rmw();
    run_cmd("pre_rst", 2'b01, 13'h0040, 32'h00007FFF);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_addr = 13'h0040; bus.cmd_data = 32'h1;
    bus.rsp_ready = 1'b1;
    @(posedge CK); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_mid wr_cycle", {30'h0, sram_cs, sram_we}, 32'h3);
    RST_N = 1'b0;
    #1;
    chk("rst_mid cs_drop", 32'(sram_cs), 32'd0);
    chk("rst_mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge CK); #1;
    RST_N = 1'b1;
    ref_sat = 0;
    @(posedge CK); #1;
    chk("rst_mid ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mid mem_kept", mem[13'h0040], 32'h00007FFF);
    chk("rst_mid sat_count", 32'(sat_count), 32'(ref_sat));
    chk("rst_mid no_rsp", 32'(bus.rsp_valid), 32'd0);
    $display("txn reset during rmw addr=0040 mem=%h", mem[13'h0040]);
    run_cmd("post_rst_read", 2'b00, 13'h0040, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rmw_sat();
    test_backpressure();
    test_reserved();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
